vector_extension_sequencer: RTL and testbench



---
 rtl/dragonfang_pkg.sv | 57 +++++
 rtl/vector_extension_sequencer_if.sv | 28 ++
 rtl/vector_extension_sequencer_slice.sv | 46 ++++
 rtl/vector_extension_sequencer.sv | 129 ++++++++++++
 tb/tb_vector_extension_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang vector unit: mode enums, the execution vector
// and the widening-factor / SEW decode helpers.
package dragonfang_pkg;

  localparam int MAX_WIDENING_FACTOR = 8;

  typedef logic [3:0] widening_factor_t;
  typedef logic [5:0] sew_t;

  typedef enum logic [2:0] {
    FRACTION_HALF    = 3'd1,
    FRACTION_QUARTER = 3'd2,
    FRACTION_EIGHTH  = 3'd3
  } fraction_mode_t;

  typedef enum logic [1:0] {
    BIT_MODE_8  = 2'd0,
    BIT_MODE_16 = 2'd1,
    BIT_MODE_32 = 2'd2
  } bit_mode_t;

  typedef enum logic [1:0] {
    EXTENSION_ZERO = 2'd1,
    EXTENSION_SIGN = 2'd2
  } extension_mode_t;

  typedef struct packed {
    fraction_mode_t  fraction_mode;
    bit_mode_t       bit_mode;
    extension_mode_t extension_mode;
  } execution_vector_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } seq_state_t;

  // Unknown encodings decode to 0 so the caller can flag them as illegal.
  function automatic widening_factor_t get_widening_factor(input fraction_mode_t m);
    case (m)
      FRACTION_HALF:    return 4'd2;
      FRACTION_QUARTER: return 4'd4;
      FRACTION_EIGHTH:  return 4'd8;
      default:          return 4'd0;
    endcase
  endfunction

  function automatic sew_t get_sew(input bit_mode_t m);
    case (m)
      BIT_MODE_8:  return 6'd8;
      BIT_MODE_16: return 6'd16;
      BIT_MODE_32: return 6'd32;
      default:     return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vector_extension_sequencer_if.sv
// Request/response bundle between issue, the extension sequencer and write-back.
interface vector_extension_sequencer_if
  import dragonfang_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_FACTOR = 8
) ();
  logic                          in_valid;
  logic                          in_ready;
  execution_vector_t             execution_vector;
  logic [DATA_WIDTH-1:0]         vs2;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         vd;
  logic [$clog2(MAX_FACTOR)-1:0] vd_index;
  logic                          out_last;
  logic                          illegal;

  modport master (
    output in_valid, execution_vector, vs2, out_ready,
    input  in_ready, out_valid, vd, vd_index, out_last, illegal
  );

  modport slave (
    input  in_valid, execution_vector, vs2, out_ready,
    output in_ready, out_valid, vd, vd_index, out_last, illegal
  );
endinterface

// File: rtl/vector_extension_sequencer_slice.sv
// Widens one source slice into a DATA_WIDTH beat; one extender per legal
// (SEW, factor) pair, selected by the latched mode.
module vector_extension_sequencer_slice
  import dragonfang_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ELEN       = 64,
  parameter int MAX_FACTOR = 8
) (
  input  logic [DATA_WIDTH/2-1:0] i_slice,
  input  sew_t                    i_sew,
  input  widening_factor_t        i_factor,
  input  logic                    i_sign,
  output logic [DATA_WIDTH-1:0]   o_beat
);

  logic [DATA_WIDTH-1:0] w_cand [9];

  for (genvar gs = 0; gs < 3; gs++) begin : g_sew
    for (genvar gf = 0; gf < 3; gf++) begin : g_fac
      localparam int SEW   = 8 << gs;
      localparam int FAC   = 2 << gf;
      localparam int DW_EL = SEW * FAC;
      if (DW_EL <= ELEN && FAC <= MAX_FACTOR && DW_EL <= DATA_WIDTH) begin : g_legal
        logic [DATA_WIDTH-1:0] w_beat;
        for (genvar j = 0; j < DATA_WIDTH / DW_EL; j++) begin : g_el
          assign w_beat[j*DW_EL +: DW_EL] =
            {{(DW_EL-SEW){i_sign & i_slice[j*SEW+SEW-1]}}, i_slice[j*SEW +: SEW]};
        end
        assign w_cand[gs*3+gf] = w_beat;
      end else begin : g_none
        assign w_cand[gs*3+gf] = '0;
      end
    end
  end

  always_comb begin
    o_beat = '0;
    for (int s = 0; s < 3; s++) begin
      for (int f = 0; f < 3; f++) begin
        if (32'(i_sew) == (8 << s) && 32'(i_factor) == (2 << f)) o_beat = w_cand[s*3+f];
      end
    end
  end

endmodule

// File: rtl/vector_extension_sequencer.sv
// Multi-beat vsext/vzext sequencer.  ST_IDLE: waiting for a request;
// ST_EMIT: presenting beat r_k of the latched request (or one illegal beat).
module vector_extension_sequencer
  import dragonfang_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ELEN       = 64,
  parameter int MAX_FACTOR = 8
) (
  input logic                   clock,
  input logic                   reset,
  input logic                   flush,
  vector_extension_sequencer_if.slave bus
);

  localparam int KW  = $clog2(MAX_FACTOR);
  localparam int LDW = $clog2(DATA_WIDTH);
  localparam int HW  = DATA_WIDTH / 2;

  seq_state_t            r_state;
  logic [KW-1:0]         r_k;
  logic [DATA_WIDTH-1:0] r_vs2;
  sew_t                  r_sew;
  widening_factor_t      r_factor;
  logic                  r_sign;
  logic                  r_illegal;

  widening_factor_t      w_factor;
  sew_t                  w_sew;
  logic                  w_ext_ok, w_legal, w_emit, w_last, w_accept;
  logic [2:0]            w_lf;
  logic [KW+LDW-1:0]     w_shift;
  logic [HW-1:0]         w_slice;
  logic [DATA_WIDTH-1:0] w_beat;

  assign w_factor = get_widening_factor(bus.execution_vector.fraction_mode);
  assign w_sew    = get_sew(bus.execution_vector.bit_mode);
  assign w_ext_ok = (bus.execution_vector.extension_mode == EXTENSION_SIGN) ||
                    (bus.execution_vector.extension_mode == EXTENSION_ZERO);
  assign w_legal  = (w_factor != '0) && (w_sew != '0) && w_ext_ok &&
                    (32'(w_sew) * 32'(w_factor) <= ELEN) && (32'(w_factor) <= MAX_FACTOR);

  assign w_emit   = (r_state == ST_EMIT);
  assign w_last   = w_emit && (r_illegal || (32'(r_k) + 32'd1 == 32'(r_factor)));
  assign w_accept = w_emit && bus.out_ready && !flush;

  assign bus.in_ready = !flush && ((r_state == ST_IDLE) || (w_accept && w_last));

  always_comb begin
    w_lf = 3'd0;
    case (r_factor)
      4'd2:    w_lf = 3'd1;
      4'd4:    w_lf = 3'd2;
      4'd8:    w_lf = 3'd3;
      default: w_lf = 3'd0;
    endcase
  end

  // Slice offset k*DATA_WIDTH/factor, with factor a power of two.
  assign w_shift = {r_k, {LDW{1'b0}}} >> w_lf;
  assign w_slice = HW'(r_vs2 >> w_shift);

  vector_extension_sequencer_slice #(
    .DATA_WIDTH (DATA_WIDTH),
    .ELEN       (ELEN),
    .MAX_FACTOR (MAX_FACTOR)
  ) u_slice (
    .i_slice  (w_slice),
    .i_sew    (r_sew),
    .i_factor (r_factor),
    .i_sign   (r_sign),
    .o_beat   (w_beat)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_vs2     <= '0;
      r_sew     <= '0;
      r_factor  <= '0;
      r_sign    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state   <= ST_EMIT;
            r_k       <= '0;
            r_vs2     <= bus.vs2;
            r_sew     <= w_sew;
            r_factor  <= w_factor;
            r_sign    <= (bus.execution_vector.extension_mode == EXTENSION_SIGN);
            r_illegal <= !w_legal;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (w_last) begin
              r_k <= '0;
              if (bus.in_valid) begin
                r_vs2     <= bus.vs2;
                r_sew     <= w_sew;
                r_factor  <= w_factor;
                r_sign    <= (bus.execution_vector.extension_mode == EXTENSION_SIGN);
                r_illegal <= !w_legal;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = w_emit;
  assign bus.vd        = (w_emit && !r_illegal) ? w_beat : '0;
  assign bus.vd_index  = w_emit ? r_k : '0;
  assign bus.out_last  = w_last;
  assign bus.illegal   = w_emit && r_illegal;

endmodule

// File: tb/tb_vector_extension_sequencer.sv
// Scoreboard bench: requests push reference beats; a negedge monitor compares
// every presented beat and the handshake against the queue front.
module tb_vector_extension_sequencer;
  import dragonfang_pkg::*;

  localparam int DW = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clock = ~clock;

  vector_extension_sequencer_if #(.DATA_WIDTH(DW), .MAX_FACTOR(8)) bus ();

  vector_extension_sequencer #(.DATA_WIDTH(DW), .ELEN(64), .MAX_FACTOR(8)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] vd;
    logic [2:0]  idx;
    logic        last;
    logic        ill;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;
  int pat_i = 0;
  logic [3:0] pat = 4'b1001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: extend every SEW element of each slice with plain arithmetic.
  function automatic void model_push(input logic [2:0] fm, input logic [1:0] bm,
                                     input logic [1:0] em, input logic [63:0] v);
    int f, s, off;
    logic [63:0] e, mask, wide;
    beat_t b;
    f = (fm == FRACTION_HALF) ? 2 : (fm == FRACTION_QUARTER) ? 4 : (fm == FRACTION_EIGHTH) ? 8 : 0;
    s = (bm == BIT_MODE_8) ? 8 : (bm == BIT_MODE_16) ? 16 : (bm == BIT_MODE_32) ? 32 : 0;
    if (f == 0 || s == 0 || !(em == EXTENSION_ZERO || em == EXTENSION_SIGN) || s * f > 64 || f > 8) begin
      b.vd = 64'd0; b.idx = 3'd0; b.last = 1'b1; b.ill = 1'b1;
      q.push_back(b);
      return;
    end
    mask = (64'd1 << s) - 64'd1;
    wide = (64'd1 << (s * f)) - 64'd1;
    for (int k = 0; k < f; k++) begin
      b.vd = 64'd0;
      for (int j = 0; j < DW / (s * f); j++) begin
        off = k * (DW / f) + j * s;
        e = (v >> off) & mask;
        if (em == EXTENSION_SIGN && e[s-1]) e = e | (wide & ~mask);
        b.vd = b.vd | (e << (j * s * f));
      end
      b.idx = 3'(k);
      b.last = (k == f - 1);
      b.ill = 1'b0;
      q.push_back(b);
    end
  endfunction

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: begin
        bus.out_ready = pat[pat_i % 4];
        pat_i++;
      end
    endcase
  end

  always @(negedge clock) begin
    logic ev, er;
    if (reset) begin
      q.delete();
    end else begin
      ev = (q.size() != 0);
      er = !flush && (!ev || (bus.out_ready && q[0].last));
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, er);
      if (ev) begin
        chk("vd", bus.vd, q[0].vd);
        chk("vd_index", bus.vd_index, q[0].idx);
        chk("out_last", bus.out_last, q[0].last);
        chk("illegal", bus.illegal, q[0].ill);
      end else begin
        chk("vd_idle_zero", bus.vd, 64'd0);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (ev && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && er)
          model_push(bus.execution_vector.fraction_mode, bus.execution_vector.bit_mode,
                     bus.execution_vector.extension_mode, bus.vs2);
      end
    end
  end

  task automatic send(input logic [2:0] fm, input logic [1:0] bm, input logic [1:0] em,
                      input logic [63:0] v);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.execution_vector.fraction_mode  = fraction_mode_t'(fm);
    bus.execution_vector.bit_mode       = bit_mode_t'(bm);
    bus.execution_vector.extension_mode = extension_mode_t'(em);
    bus.vs2 = v;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.in_ready && t < 200);
    if (!bus.in_ready) chk("send_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 300) begin
      @(posedge clock);
      t++;
    end
    #1;
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] fm;
    logic [1:0] bm, em;
    bus.in_valid = 1'b0;
    bus.vs2 = 64'd0;
    bus.execution_vector = execution_vector_t'(7'd0);
    ready_mode = 0;
    idle(3);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_vd", bus.vd, 64'd0);
    chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
    reset = 1'b0;
    idle(1);
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    send(FRACTION_HALF, BIT_MODE_32, EXTENSION_SIGN, 64'h80000000_7FFFFFFF);
    drain();
    send(FRACTION_EIGHTH, BIT_MODE_8, EXTENSION_ZERO, 64'hF0E0D0C0B0A09080);
    drain();
    ready_mode = 2; pat_i = 0;
    send(FRACTION_QUARTER, BIT_MODE_8, EXTENSION_SIGN, 64'h0000000000000080);
    drain();
    ready_mode = 0;
    send(FRACTION_QUARTER, BIT_MODE_32, EXTENSION_SIGN, 64'hDEADBEEF_12345678);
    send(FRACTION_HALF, BIT_MODE_8, EXTENSION_ZERO, {$urandom, $urandom});
    drain();
    send(FRACTION_HALF, BIT_MODE_16, EXTENSION_SIGN, {$urandom, $urandom});
    send(FRACTION_HALF, BIT_MODE_16, EXTENSION_ZERO, {$urandom, $urandom});
    drain();

    send(FRACTION_EIGHTH, BIT_MODE_8, EXTENSION_SIGN, {$urandom, $urandom});
    idle(2);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("post_flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
    drain();

    send(FRACTION_EIGHTH, BIT_MODE_8, EXTENSION_ZERO, {$urandom, $urandom});
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_vd", bus.vd, 64'd0);
    chk("midrst_vd_index", {61'd0, bus.vd_index}, 64'd0);
    chk("midrst_out_last", {63'd0, bus.out_last}, 64'd0);
    chk("midrst_illegal", {63'd0, bus.illegal}, 64'd0);
    idle(2);
    reset = 1'b0;
    idle(1);

    ready_mode = 1;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        fm = 3'($urandom_range(1, 3));
        bm = 2'($urandom_range(0, 2));
        em = 2'($urandom_range(1, 2));
      end else begin
        fm = 3'($urandom_range(0, 7));
        bm = 2'($urandom_range(0, 3));
        em = 2'($urandom_range(0, 3));
      end
      send(fm, bm, em, {$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 3));
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        idle($urandom_range(1, 4));
      end
    end
    ready_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
